// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C target responder: FSM state encoding,
// default register word size and the bus levels used for ACK / NACK.
// ---------------------------------------------------------------------------
package i2c_pkg;

    // Default number of data bytes per register word (sent MSB byte first).
    localparam int I2C_DATA_BYTES_DEFAULT = 2;

    // SDA level seen or driven in the acknowledge bit slot.
    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_REG       = 4'd3,
        ST_REG_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RACK_WAIT = 4'd8
    } i2c_state_t;

    // Address byte is 7 address bits (MSB first) followed by R/W.
    function automatic logic addr_match(input logic [7:0] addr_byte,
                                        input logic [6:0] id);
        return (addr_byte[7:1] == id);
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// ---------------------------------------------------------------------------
// i2c_bus_sync
// Two-flop synchronizers for SDA/SCL plus one history flop per line, and
// single-cycle event pulses derived only from the synchronized values.
//
// Ports
//   clk        system clock (rising edge)
//   reset      asynchronous active-low reset; all flops reset to 1 (idle bus)
//   sda_in     raw SDA line level
//   scl_in     raw SCL line level
//   sda_s      synchronized SDA level
//   start_det  SDA fell while SCL high
//   stop_det   SDA rose while SCL high
//   scl_rise   synchronized SCL rising edge
//   scl_fall   synchronized SCL falling edge
// ---------------------------------------------------------------------------
module i2c_bus_sync (
    input  logic clk,
    input  logic reset,
    input  logic sda_in,
    input  logic scl_in,
    output logic sda_s,
    output logic start_det,
    output logic stop_det,
    output logic scl_rise,
    output logic scl_fall
);

    logic sda_p0, sda_p1, sda_p2;
    logic scl_p0, scl_p1, scl_p2;

    // p0/p1: metastability chain, p2: previous synchronized value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sda_p0 <= 1'b1;
            sda_p1 <= 1'b1;
            sda_p2 <= 1'b1;
            scl_p0 <= 1'b1;
            scl_p1 <= 1'b1;
            scl_p2 <= 1'b1;
        end else begin
            sda_p0 <= sda_in;
            sda_p1 <= sda_p0;
            sda_p2 <= sda_p1;
            scl_p0 <= scl_in;
            scl_p1 <= scl_p0;
            scl_p2 <= scl_p1;
        end
    end

    assign sda_s     = sda_p1;
    assign scl_rise  =  scl_p1 & ~scl_p2;
    assign scl_fall  = ~scl_p1 &  scl_p2;
    // SCL must be high on both samples so an SDA change around an SCL edge
    // is never mistaken for a bus condition.
    assign start_det = scl_p1 & scl_p2 &  sda_p2 & ~sda_p1;
    assign stop_det  = scl_p1 & scl_p2 & ~sda_p2 &  sda_p1;

endmodule

// File: rtl/i2c_target_responder.sv
// ---------------------------------------------------------------------------
// i2c_target_responder
// I2C target exposing a register file through a pointer/word interface.
// Write: [addr+W] [reg] [data bytes ...] -> one slave_write_en strobe per
// DATA_BYTES bytes, pointer auto-increments after each strobe.
// Read:  [addr+R] -> slave_data_in0 shifted out MSB first, pointer
// auto-increments after the last byte of each word.
//
// Ports
//   clk              system clock (rising edge)
//   reset            asynchronous active-low reset
//   chip_id          7-bit target address
//   slave_reg_addr   register pointer
//   slave_write_en   one-clk write strobe
//   slave_data_out0  assembled write word (valid with the strobe)
//   slave_data_in0   read word for slave_reg_addr
//   sda_in/scl_in    bus line levels
//   sda_out/sda_oen  SDA driver (oen=1 releases, sda_out tied 0)
//   scl_out/scl_oen  SCL driver, permanently released
//   busy             addressed transaction in progress
//   done             one-clk pulse on STOP ending an addressed transaction
// ---------------------------------------------------------------------------
module i2c_target_responder
    import i2c_pkg::*;
#(
    parameter int DATA_BYTES = I2C_DATA_BYTES_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              chip_id,
    output logic [7:0]              slave_reg_addr,
    output logic                    slave_write_en,
    output logic [8*DATA_BYTES-1:0] slave_data_out0,
    input  logic [8*DATA_BYTES-1:0] slave_data_in0,
    input  logic                    sda_in,
    input  logic                    scl_in,
    output logic                    sda_out,
    output logic                    sda_oen,
    output logic                    scl_out,
    output logic                    scl_oen,
    output logic                    busy,
    output logic                    done
);

    localparam int         DW        = 8 * DATA_BYTES;
    localparam logic [7:0] LAST_BYTE = 8'(DATA_BYTES - 1);

    logic          sda_s;
    logic          start_det;
    logic          stop_det;
    logic          scl_rise;
    logic          scl_fall;

    i2c_state_t    state;
    logic [3:0]    bit_cnt;
    logic [7:0]    byte_cnt;
    logic [7:0]    shift_byte;
    logic [7:0]    next_byte;
    logic [DW-1:0] wr_word;
    logic [DW-1:0] rd_word;
    logic          rw;
    logic          ack_phase;
    logic          nack_seen;
    logic          inc_pend;

    i2c_bus_sync u_bus_sync (
        .clk       (clk),
        .reset     (reset),
        .sda_in    (sda_in),
        .scl_in    (scl_in),
        .sda_s     (sda_s),
        .start_det (start_det),
        .stop_det  (stop_det),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall)
    );

    // Open-drain: only ever pull low, never drive SCL.
    assign sda_out = 1'b0;
    assign scl_out = 1'b0;
    assign scl_oen = 1'b1;

    // Byte as it will look once the bit on SDA right now is shifted in.
    assign next_byte = {shift_byte[6:0], sda_s};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= ST_IDLE;
            bit_cnt         <= 4'd0;
            byte_cnt        <= 8'd0;
            shift_byte      <= 8'd0;
            wr_word         <= '0;
            rd_word         <= '0;
            rw              <= 1'b0;
            ack_phase       <= 1'b0;
            nack_seen       <= 1'b0;
            inc_pend        <= 1'b0;
            sda_oen         <= 1'b1;
            slave_reg_addr  <= 8'h00;
            slave_write_en  <= 1'b0;
            slave_data_out0 <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            slave_write_en <= 1'b0;
            done           <= 1'b0;

            // Pointer moves the cycle after the strobe so the strobe sees
            // the address the word belongs to.
            if (inc_pend) begin
                slave_reg_addr <= slave_reg_addr + 8'd1;
                inc_pend       <= 1'b0;
            end

            if (stop_det) begin
                state     <= ST_IDLE;
                sda_oen   <= 1'b1;
                bit_cnt   <= 4'd0;
                byte_cnt  <= 8'd0;
                ack_phase <= 1'b0;
                nack_seen <= 1'b0;
                if (busy) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end else if (start_det) begin
                // START or repeated START: any partial word is dropped,
                // the pointer is kept.
                state     <= ST_ADDR;
                sda_oen   <= 1'b1;
                bit_cnt   <= 4'd0;
                byte_cnt  <= 8'd0;
                ack_phase <= 1'b0;
                nack_seen <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                    end

                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_byte <= next_byte;
                            bit_cnt    <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= 4'd0;
                                if (addr_match(next_byte, chip_id)) begin
                                    rw    <= sda_s;
                                    busy  <= 1'b1;
                                    state <= ST_ADDR_ACK;
                                end else begin
                                    busy  <= 1'b0;
                                    state <= ST_IDLE;
                                end
                            end
                        end
                    end

                    // ACK slots: first SCL fall pulls SDA low, second one
                    // (end of the 9th clock) hands the line to the next phase.
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_oen   <= I2C_ACK;
                                ack_phase <= 1'b1;
                            end else begin
                                ack_phase <= 1'b0;
                                bit_cnt   <= 4'd0;
                                byte_cnt  <= 8'd0;
                                if (rw) begin
                                    sda_oen <= slave_data_in0[DW-1];
                                    rd_word <= {slave_data_in0[DW-2:0], 1'b0};
                                    state   <= ST_RDATA;
                                end else begin
                                    sda_oen <= 1'b1;
                                    state   <= ST_REG;
                                end
                            end
                        end
                    end

                    ST_REG: begin
                        if (scl_rise) begin
                            shift_byte <= next_byte;
                            bit_cnt    <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt        <= 4'd0;
                                slave_reg_addr <= next_byte;
                                state          <= ST_REG_ACK;
                            end
                        end
                    end

                    ST_REG_ACK, ST_WDATA_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_oen   <= I2C_ACK;
                                ack_phase <= 1'b1;
                            end else begin
                                ack_phase <= 1'b0;
                                sda_oen   <= 1'b1;
                                state     <= ST_WDATA;
                            end
                        end
                    end

                    ST_WDATA: begin
                        if (scl_rise) begin
                            // Word shifts bitwise; after DATA_BYTES full bytes
                            // every stale bit has been pushed out.
                            wr_word    <= {wr_word[DW-2:0], sda_s};
                            shift_byte <= next_byte;
                            bit_cnt    <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= 4'd0;
                                state   <= ST_WDATA_ACK;
                                if (byte_cnt == LAST_BYTE) begin
                                    byte_cnt        <= 8'd0;
                                    slave_write_en  <= 1'b1;
                                    slave_data_out0 <= {wr_word[DW-2:0], sda_s};
                                    inc_pend        <= 1'b1;
                                end else begin
                                    byte_cnt <= byte_cnt + 8'd1;
                                end
                            end
                        end
                    end

                    ST_RDATA: begin
                        // bit_cnt counts bits already sampled by the controller.
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt <= 4'd0;
                                sda_oen <= 1'b1;
                                state   <= ST_RACK_WAIT;
                            end else begin
                                sda_oen <= rd_word[DW-1];
                                rd_word <= {rd_word[DW-2:0], 1'b0};
                            end
                        end
                    end

                    ST_RACK_WAIT: begin
                        // After a NACK the line stays released until STOP/START.
                        if (!nack_seen) begin
                            if (scl_rise) begin
                                // Word is consumed whether or not the controller
                                // wants more, so the pointer advances here.
                                if (byte_cnt == LAST_BYTE)
                                    slave_reg_addr <= slave_reg_addr + 8'd1;
                                if (sda_s == I2C_NACK)
                                    nack_seen <= 1'b1;
                                else
                                    ack_phase <= 1'b1;
                            end else if (scl_fall && ack_phase) begin
                                ack_phase <= 1'b0;
                                bit_cnt   <= 4'd0;
                                state     <= ST_RDATA;
                                if (byte_cnt == LAST_BYTE) begin
                                    // Pointer already advanced: fetch next word.
                                    byte_cnt <= 8'd0;
                                    sda_oen  <= slave_data_in0[DW-1];
                                    rd_word  <= {slave_data_in0[DW-2:0], 1'b0};
                                end else begin
                                    byte_cnt <= byte_cnt + 8'd1;
                                    sda_oen  <= rd_word[DW-1];
                                    rd_word  <= {rd_word[DW-2:0], 1'b0};
                                end
                            end
                        end
                    end

                    default: begin
                        state   <= ST_IDLE;
                        sda_oen <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_responder.sv
module tb_i2c_target_responder;
    import i2c_pkg::*;

    localparam int DW = 16;
    localparam int T  = 10;   // clk cycles per quarter SCL period

    logic          clk;
    logic          reset;
    logic [6:0]    chip_id;
    logic [7:0]    slave_reg_addr;
    logic          slave_write_en;
    logic [DW-1:0] slave_data_out0;
    logic [DW-1:0] slave_data_in0;
    logic          sda_in, scl_in;
    logic          sda_out, sda_oen, scl_out, scl_oen;
    logic          busy, done;

    logic          sda_drv, scl_drv;

    int checks   = 0;
    int failures = 0;

    int            strobe_cnt = 0;
    int            done_cnt   = 0;
    int            busy_cycles = 0;
    logic [7:0]    wr_addr_log [8];
    logic [DW-1:0] wr_data_log [8];

    i2c_target_responder #(.DATA_BYTES(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .chip_id         (chip_id),
        .slave_reg_addr  (slave_reg_addr),
        .slave_write_en  (slave_write_en),
        .slave_data_out0 (slave_data_out0),
        .slave_data_in0  (slave_data_in0),
        .sda_in          (sda_in),
        .scl_in          (scl_in),
        .sda_out         (sda_out),
        .sda_oen         (sda_oen),
        .scl_out         (scl_out),
        .scl_oen         (scl_oen),
        .busy            (busy),
        .done            (done)
    );

    // Wired-AND open-drain bus
    assign sda_in = sda_drv & (sda_oen | sda_out);
    assign scl_in = scl_drv & (scl_oen | scl_out);

    // Register file read side: word at 0x06 differs so a pointer step is visible
    assign slave_data_in0 = (slave_reg_addr == 8'h06) ? 16'h5AC3 : 16'hB2B2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (slave_write_en) begin
            if (strobe_cnt < 8) begin
                wr_addr_log[strobe_cnt] = slave_reg_addr;
                wr_data_log[strobe_cnt] = slave_data_out0;
            end
            strobe_cnt++;
        end
        if (done) done_cnt++;
        if (busy) busy_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_t();
        repeat (T) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        sda_drv = 1'b1; wait_t();
        scl_drv = 1'b1; wait_t();
        sda_drv = 1'b0; wait_t();
        scl_drv = 1'b0; wait_t();
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; wait_t();
        scl_drv = 1'b1; wait_t();
        sda_drv = 1'b1; wait_t();
    endtask

    task automatic clock_bit(input logic b, output logic s);
        sda_drv = b;    wait_t();
        scl_drv = 1'b1; wait_t();
        s = sda_in;     wait_t();
        scl_drv = 1'b0; wait_t();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic ack_lvl, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            b[i] = s;
        end
        clock_bit(ack_lvl, s);
    endtask

    initial begin
        logic       a0, a1, a2, a3, s;
        logic [7:0] b0, b1, b2, b3;
        int         sc0, dc0, bc0;
        int         waited;

        reset   = 1'b0;
        chip_id = 7'h0F;
        sda_drv = 1'b1;
        scl_drv = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_sda_oen", sda_oen, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_wen", slave_write_en, 1'b0);
        check("rst_ptr", slave_reg_addr, 8'h00);
        check("rst_dout", slave_data_out0, 16'h0000);
        check("rst_state", dut.state, ST_IDLE);
        check("rst_scl_oen", scl_oen, 1'b1);

        reset = 1'b1;
        wait_t();

        // Write chip 0x0F reg 0x00 data 0xA1A1
        sc0 = strobe_cnt; dc0 = done_cnt;
        bus_start();
        write_byte(8'h1E, a0);
        write_byte(8'h00, a1);
        write_byte(8'hA1, a2);
        write_byte(8'hA1, a3);
        check("w1_busy", busy, 1'b1);
        bus_stop();
        wait_t();
        check("w1_ack_addr", a0, 1'b0);
        check("w1_ack_reg", a1, 1'b0);
        check("w1_ack_d0", a2, 1'b0);
        check("w1_ack_d1", a3, 1'b0);
        check("w1_strobes", strobe_cnt - sc0, 1);
        check("w1_addr", wr_addr_log[sc0], 8'h00);
        check("w1_data", wr_data_log[sc0], 16'hA1A1);
        check("w1_done", done_cnt - dc0, 1);
        check("w1_ptr", slave_reg_addr, 8'h01);
        check("w1_busy_end", busy, 1'b0);

        // Address mismatch: 0x10 vs chip 0x0F
        sc0 = strobe_cnt; dc0 = done_cnt; bc0 = busy_cycles;
        bus_start();
        write_byte(8'h20, a0);
        write_byte(8'h00, a1);
        bus_stop();
        wait_t();
        check("nm_nack", a0, 1'b1);
        check("nm_ignored", a1, 1'b1);
        check("nm_strobes", strobe_cnt - sc0, 0);
        check("nm_busy", busy_cycles - bc0, 0);
        check("nm_done", done_cnt - dc0, 0);

        // Write reg 0x05, repeated START read of two words
        bus_start();
        write_byte(8'h1E, a0);
        write_byte(8'h05, a1);
        bus_start();
        write_byte(8'h1F, a2);
        read_byte(1'b0, b0);
        read_byte(1'b0, b1);
        check("rd_ptr_word", slave_reg_addr, 8'h06);
        read_byte(1'b0, b2);
        read_byte(1'b1, b3);
        bus_stop();
        wait_t();
        check("rd_ack_w", a0 | a1, 1'b0);
        check("rd_ack_r", a2, 1'b0);
        check("rd_b0", b0, 8'hB2);
        check("rd_b1", b1, 8'hB2);
        check("rd_b2", b2, 8'h5A);
        check("rd_b3", b3, 8'hC3);
        check("rd_ptr_end", slave_reg_addr, 8'h07);
        check("rd_sda_rel", sda_oen, 1'b1);

        // Pointer wrap 0xFF -> 0x00
        sc0 = strobe_cnt;
        bus_start();
        write_byte(8'h1E, a0);
        write_byte(8'hFF, a0);
        write_byte(8'hC3, a0);
        write_byte(8'hC3, a0);
        write_byte(8'hD4, a0);
        write_byte(8'hD4, a1);
        bus_stop();
        wait_t();
        check("wr_strobes", strobe_cnt - sc0, 2);
        check("wr_addr0", wr_addr_log[sc0], 8'hFF);
        check("wr_data0", wr_data_log[sc0], 16'hC3C3);
        check("wr_addr1", wr_addr_log[sc0 + 1], 8'h00);
        check("wr_data1", wr_data_log[sc0 + 1], 16'hD4D4);
        check("wr_ptr", slave_reg_addr, 8'h01);

        // STOP after 4 bits of the second data byte
        sc0 = strobe_cnt;
        bus_start();
        write_byte(8'h1E, a0);
        write_byte(8'h20, a0);
        write_byte(8'h11, a0);
        for (int i = 0; i < 4; i++) clock_bit(1'b0, s);
        bus_stop();
        wait_t();
        check("ab_strobes", strobe_cnt - sc0, 0);
        check("ab_state", dut.state, ST_IDLE);
        check("ab_sda_rel", sda_oen, 1'b1);
        check("ab_busy", busy, 1'b0);
        check("ab_ptr", slave_reg_addr, 8'h20);

        // Reset while the target drives a 0 data bit (0xB2: 1 then 0)
        sc0 = strobe_cnt;
        bus_start();
        write_byte(8'h1F, a0);
        clock_bit(1'b1, s);
        check("rr_ack", a0, 1'b0);
        check("rr_bit7", s, 1'b1);
        waited = 0;
        while (sda_oen !== 1'b0 && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        check("rr_driving", sda_oen, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        check("rr_sda_oen", sda_oen, 1'b1);
        check("rr_busy", busy, 1'b0);
        check("rr_ptr", slave_reg_addr, 8'h00);
        check("rr_dout", slave_data_out0, 16'h0000);
        check("rr_wen", slave_write_en, 1'b0);
        check("rr_done", done, 1'b0);
        check("rr_state", dut.state, ST_IDLE);
        scl_drv = 1'b1;
        sda_drv = 1'b1;
        wait_t();
        reset = 1'b1;
        wait_t();
        check("rr_strobes", strobe_cnt - sc0, 0);
        check("rr_sda_after", sda_oen, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
